// File: rtl/xor_accum_if.sv
// Handshake bundle for xor_accum: input beat side and result side.
// The block itself connects through the slave modport.
interface xor_accum_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             parity;
   logic             frame_done;

   modport master (
      output in_valid, a, b, mode, out_ready,
      input  in_ready, out_valid, c, parity, frame_done
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready,
      output in_ready, out_valid, c, parity, frame_done
   );
endinterface

// File: rtl/xor_accum.sv
// XOR / XNOR / frame- and running-accumulate unit with a
// one-deep registered result and valid/ready on both sides.
module xor_accum #(
   parameter int WIDTH   = 8,
   parameter int ACC_LEN = 4
) (
   input logic       clk,
   input logic       rst_n,
   xor_accum_if.slave io
);
   localparam int CW = $clog2(ACC_LEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] c_q;
   logic [CW-1:0]    cnt;
   logic             par_q;
   logic             fd_q;

   logic             accept;
   logic             consume;
   logic             partial;
   logic             last;
   logic             produce;
   logic [WIDTH-1:0] mix;
   logic [WIDTH-1:0] nacc;
   logic [WIDTH-1:0] res;

   // Datapath: a partial frame is dropped by any non-frame beat,
   // so mode 11 starts from zero instead of the partial acc.
   always_comb begin
      mix     = io.a ^ io.b;
      partial = (cnt != '0);
      accept  = io.in_valid && io.in_ready;
      consume = io.out_valid && io.out_ready;
      last    = (io.mode == 2'b10) && (cnt == CW'(ACC_LEN - 1));
      if (io.mode == 2'b10 || !partial)
         nacc = acc ^ mix;
      else
         nacc = mix;
      produce = accept && (io.mode != 2'b10 || last);
      res     = nacc;
      unique case (io.mode)
         2'b00:   res = mix;
         2'b01:   res = ~mix;
         default: res = nacc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept)
         state_nxt = produce ? OUT : ACC;
      else if (consume)
         state_nxt = IDLE;
   end

   always_comb begin
      io.out_valid  = (state == OUT);
      io.in_ready   = (state != OUT) || io.out_ready;
      io.c          = c_q;
      io.parity     = par_q;
      io.frame_done = fd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         cnt   <= '0;
         c_q   <= '0;
         par_q <= 1'b0;
         fd_q  <= 1'b0;
      end else if (accept) begin
         if (produce) begin
            c_q   <= res;
            par_q <= ^res;
            fd_q  <= (io.mode == 2'b10);
         end
         unique case (io.mode)
            2'b10: begin
               acc <= last ? '0 : nacc;
               cnt <= last ? '0 : cnt + CW'(1);
            end
            2'b11: begin
               acc <= nacc;
               cnt <= '0;
            end
            default: begin
               if (partial)
                  acc <= '0;
               cnt <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_xor_accum.sv
// Directed bench for xor_accum (WIDTH=8, ACC_LEN=4) with
// hand-computed expectations.
module tb_xor_accum;
   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;

   xor_accum_if #(.WIDTH(8)) bus ();

   xor_accum #(
      .WIDTH  (8),
      .ACC_LEN(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] m,
                       input logic [7:0] va,
                       input logic [7:0] vb);
      bus.mode     = m;
      bus.a        = va;
      bus.b        = vb;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      n_total       = 0;
      n_bad         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.mode      = 2'b00;
      bus.out_ready = 1'b1;
      #12;
      chk("rst_ov", 64'(bus.out_valid), 64'd0);
      chk("rst_c", 64'(bus.c), 64'h00);
      chk("rst_par", 64'(bus.parity), 64'd0);
      chk("rst_fd", 64'(bus.frame_done), 64'd0);
      chk("rst_ir", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_ir", 64'(bus.in_ready), 64'd1);

      // xor
      send(2'b00, 8'hA5, 8'h0F);
      chk("xor_ov", 64'(bus.out_valid), 64'd1);
      chk("xor_c", 64'(bus.c), 64'hAA);
      chk("xor_par", 64'(bus.parity), 64'd0);
      chk("xor_fd", 64'(bus.frame_done), 64'd0);

      // xnor
      send(2'b01, 8'hFF, 8'h00);
      chk("xnor1_c", 64'(bus.c), 64'h00);
      chk("xnor1_par", 64'(bus.parity), 64'd0);
      send(2'b01, 8'h01, 8'h00);
      chk("xnor2_c", 64'(bus.c), 64'hFE);
      chk("xnor2_par", 64'(bus.parity), 64'd1);

      // frame of four
      send(2'b10, 8'h01, 8'h00);
      chk("fr_b1_ov", 64'(bus.out_valid), 64'd0);
      send(2'b10, 8'h02, 8'h00);
      chk("fr_b2_ov", 64'(bus.out_valid), 64'd0);
      send(2'b10, 8'h04, 8'h00);
      chk("fr_b3_ov", 64'(bus.out_valid), 64'd0);
      send(2'b10, 8'h08, 8'h00);
      chk("fr_ov", 64'(bus.out_valid), 64'd1);
      chk("fr_c", 64'(bus.c), 64'h0F);
      chk("fr_par", 64'(bus.parity), 64'd0);
      chk("fr_fd", 64'(bus.frame_done), 64'd1);

      // partial frame discarded by running mode
      send(2'b10, 8'h55, 8'h00);
      chk("pd_ov", 64'(bus.out_valid), 64'd0);
      send(2'b11, 8'h03, 8'h00);
      chk("run1_c", 64'(bus.c), 64'h03);
      chk("run1_fd", 64'(bus.frame_done), 64'd0);
      send(2'b11, 8'h05, 8'h00);
      chk("run2_c", 64'(bus.c), 64'h06);
      chk("run2_fd", 64'(bus.frame_done), 64'd0);
      chk("run2_par", 64'(bus.parity), 64'd0);
      @(posedge clk);
      #1;
      chk("drain_ov", 64'(bus.out_valid), 64'd0);

      // backpressure
      bus.out_ready = 1'b0;
      bus.mode      = 2'b00;
      bus.a         = 8'h12;
      bus.b         = 8'h00;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      chk("bp1_ov", 64'(bus.out_valid), 64'd1);
      chk("bp1_c", 64'(bus.c), 64'h12);
      chk("bp1_ir", 64'(bus.in_ready), 64'd0);
      bus.a = 8'h34;
      @(posedge clk);
      #1;
      chk("bp_hold_c", 64'(bus.c), 64'h12);
      chk("bp_hold_ov", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_ir", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp2_ov", 64'(bus.out_valid), 64'd1);
      chk("bp2_c", 64'(bus.c), 64'h34);
      @(posedge clk);
      #1;
      chk("bp_end_ov", 64'(bus.out_valid), 64'd0);

      // reset mid-frame
      send(2'b10, 8'hFF, 8'h00);
      send(2'b10, 8'hFF, 8'h00);
      chk("mf_ov", 64'(bus.out_valid), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_c", 64'(bus.c), 64'h00);
      chk("arst_ir", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(2'b10, 8'h11, 8'h00);
      send(2'b10, 8'h11, 8'h00);
      send(2'b10, 8'h11, 8'h00);
      chk("rf_b3_ov", 64'(bus.out_valid), 64'd0);
      send(2'b10, 8'h11, 8'h00);
      chk("rf_ov", 64'(bus.out_valid), 64'd1);
      chk("rf_c", 64'(bus.c), 64'h00);
      chk("rf_fd", 64'(bus.frame_done), 64'd1);

      // running accumulate from a cleared acc, b nonzero
      send(2'b11, 8'h0F, 8'hF0);
      chk("run3_c", 64'(bus.c), 64'hFF);
      chk("run3_par", 64'(bus.parity), 64'd0);
      send(2'b11, 8'h01, 8'h00);
      chk("run4_c", 64'(bus.c), 64'hFE);
      chk("run4_par", 64'(bus.parity), 64'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
